// File: rtl/iob_axis2axi_in_feeder_if.sv
// Bus bundle between the frame feeder and its neighbours.
//   s_axis_*      : source AXIS stream into the feeder
//   axis_out_*    : gated stream towards the write stage FIFO
//   config_out_*  : write stage config port (base address + start strobe)
// Signal names keep the feeder-relative _i/_o suffixes so they line up with
// the write stage port list.
// modport master : feeder side
// modport slave  : environment side (source + write stage)
interface iob_axis2axi_in_feeder_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int DATA_W     = 32
);
  logic [DATA_W-1:0]     s_axis_data_i;
  logic                  s_axis_valid_i;
  logic                  s_axis_last_i;
  logic                  s_axis_ready_o;
  logic [DATA_W-1:0]     axis_out_data_o;
  logic                  axis_out_valid_o;
  logic                  axis_out_ready_i;
  logic [AXI_ADDR_W-1:0] config_out_addr_o;
  logic                  config_out_valid_o;
  logic                  config_out_ready_i;

  modport master (
    input  s_axis_data_i, s_axis_valid_i, s_axis_last_i,
    input  axis_out_ready_i, config_out_ready_i,
    output s_axis_ready_o, axis_out_data_o, axis_out_valid_o,
    output config_out_addr_o, config_out_valid_o
  );

  modport slave (
    output s_axis_data_i, s_axis_valid_i, s_axis_last_i,
    output axis_out_ready_i, config_out_ready_i,
    input  s_axis_ready_o, axis_out_data_o, axis_out_valid_o,
    input  config_out_addr_o, config_out_valid_o
  );
endinterface

// File: rtl/iob_axis2axi_in_feeder.sv
// Frame sequencer in front of the AXIS-to-AXI write stage.
// Takes a descriptor (base address, word count), programs the write stage
// config port, gates exactly that many words from the source stream into the
// write stage, waits for the write stage to drain and go idle, then pulses done.
// Ports:
//   clk_i, rst_n_i       : clock, synchronous active-low reset
//   start_i              : descriptor strobe, only honoured while idle_o=1
//   start_addr_i/len_i   : frame base byte address / length in words
//   idle_o               : ready for a new descriptor
//   done_o               : one-cycle completion pulse
//   short_o              : last frame was cut short by s_axis_last_i (sticky)
//   word_count_o         : words forwarded in current/last frame
//   bus                  : source stream, output stream and config port
module iob_axis2axi_in_feeder #(
  parameter int AXI_ADDR_W = 32,
  parameter int DATA_W     = 32,  // write stage only supports 32
  parameter int LEN_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [AXI_ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]      start_len_i,
  output logic                  idle_o,
  output logic                  done_o,
  output logic                  short_o,
  output logic [LEN_W-1:0]      word_count_o,
  iob_axis2axi_in_feeder_if.master bus
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] CONFIG      = 3'd1;
  localparam logic [2:0] STREAM      = 3'd2;
  localparam logic [2:0] DRAIN_GUARD = 3'd3;
  localparam logic [2:0] DRAIN       = 3'd4;

  logic [2:0]            state_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      count_q;
  logic                  short_q;
  logic                  done_zero_q;  // pulse for zero-length descriptors

  logic in_stream;
  logic xfer;
  logic last_word;

  // The write stage pushes into its FIFO on valid alone, so a word is only
  // presented when the write stage is ready in that very cycle.
  always_comb begin
    in_stream = (state_q == STREAM);
    xfer      = in_stream & bus.s_axis_valid_i & bus.axis_out_ready_i;
    // len_q >= 1 whenever STREAM is reachable, so len_q-1 never underflows;
    // this compare also lets len = 2^LEN_W-1 finish without count wrapping.
    last_word = (count_q == len_q - LEN_W'(1));
  end

  assign bus.s_axis_ready_o     = in_stream & bus.axis_out_ready_i;
  assign bus.axis_out_valid_o   = xfer;
  assign bus.axis_out_data_o    = bus.s_axis_data_i;
  assign bus.config_out_valid_o = (state_q == CONFIG);
  assign bus.config_out_addr_o  = addr_q;

  assign idle_o       = (state_q == IDLE);
  assign done_o       = done_zero_q | ((state_q == DRAIN) & bus.config_out_ready_i);
  assign short_o      = short_q;
  assign word_count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      short_q     <= 1'b0;
      done_zero_q <= 1'b0;
    end else begin
      done_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q  <= start_addr_i;
            len_q   <= start_len_i;
            count_q <= '0;
            short_q <= 1'b0;
            if (start_len_i == '0) done_zero_q <= 1'b1;
            else                   state_q     <= CONFIG;
          end
        end
        CONFIG: begin
          if (bus.config_out_ready_i) state_q <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            count_q <= count_q + LEN_W'(1);
            // Reaching len wins over an early last on the same word.
            if (last_word) begin
              state_q <= DRAIN_GUARD;
            end else if (bus.s_axis_last_i) begin
              short_q <= 1'b1;
              state_q <= DRAIN_GUARD;
            end
          end
        end
        // The write stage's FIFO-empty flag trails the last push by a cycle,
        // so its ready is not trusted until one cycle after the final word.
        DRAIN_GUARD: state_q <= DRAIN;
        DRAIN: begin
          if (bus.config_out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_axis2axi_in_feeder.sv
module tb_iob_axis2axi_in_feeder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] start_len;
  logic          idle, done, short_f;
  logic [LW-1:0] word_count;

  int n_chk  = 0;
  int n_fail = 0;

  iob_axis2axi_in_feeder_if #(.AXI_ADDR_W(AW), .DATA_W(DW)) bus ();

  iob_axis2axi_in_feeder #(.AXI_ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .start_addr_i (start_addr),
    .start_len_i  (start_len),
    .idle_o       (idle),
    .done_o       (done),
    .short_o      (short_f),
    .word_count_o (word_count),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] seed, input int i);
    return seed ^ (32'(i) * 32'h9E37_79B1);
  endfunction

  task automatic quiet_inputs();
    start                  = 1'b0;
    bus.s_axis_valid_i     = 1'b0;
    bus.s_axis_last_i      = 1'b0;
    bus.s_axis_data_i      = '0;
    bus.axis_out_ready_i   = 1'b0;
    bus.config_out_ready_i = 1'b0;
  endtask

  // Reference: a frame forwards n = min(len, position of first last) words,
  // in source order, only while the config handshake is done and fewer than n
  // words have gone; done comes on the first config-ready cycle at least two
  // cycles after the final word. rdy_mode: 0 always, 1 toggle, 2 random.
  task automatic run_frame(input logic [31:0] addr, input int len, input int last_pos,
                           input int rdy_mode, input int val_mode, input int cfg_hold,
                           input int abort_at);
    int n, fwd, src_idx, cyc, last_cyc, budget;
    bit cfg_pend, fin, in_fwd, exp_done;
    logic [31:0] seed;
    n      = (last_pos > 0 && last_pos < len) ? last_pos : len;
    seed   = $urandom;
    budget = len * 8 + 200;

    @(posedge clk); #1;
    quiet_inputs();
    start      = 1'b1;
    start_addr = addr;
    start_len  = LW'(len);
    @(negedge clk);
    chk("idle_before_start", idle, 1);
    @(posedge clk); #1;
    start = 1'b0;

    if (len == 0) begin
      @(negedge clk);
      chk("zero_done", done, 1);
      chk("zero_idle", idle, 1);
      chk("zero_cfg_valid", bus.config_out_valid_o, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_done_once", done, 0);
      chk("zero_idle2", idle, 1);
      chk("zero_count", word_count, 0);
      chk("zero_short", short_f, 0);
      return;
    end

    cfg_pend = 1; fwd = 0; src_idx = 0; cyc = 0; last_cyc = -1; fin = 0;
    while (!fin && cyc < budget) begin
      if (abort_at > 0 && fwd == abort_at) begin
        rst_n = 1'b0;
        quiet_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", idle, 1);
        chk("abort_done", done, 0);
        chk("abort_s_ready", bus.s_axis_ready_o, 0);
        chk("abort_out_valid", bus.axis_out_valid_o, 0);
        chk("abort_cfg_valid", bus.config_out_valid_o, 0);
        chk("abort_short", short_f, 0);
        chk("abort_count", word_count, 0);
        return;
      end
      // stray starts mid-frame must be ignored
      start     = ($urandom_range(0, 3) == 0);
      start_len = LW'($urandom_range(0, 50));
      case (rdy_mode)
        0:       bus.axis_out_ready_i = 1'b1;
        1:       bus.axis_out_ready_i = (cyc % 2 == 0);
        default: bus.axis_out_ready_i = 1'($urandom_range(0, 1));
      endcase
      bus.s_axis_valid_i = (val_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.s_axis_data_i  = src_word(seed, src_idx);
      bus.s_axis_last_i  = (last_pos > 0 && src_idx == last_pos - 1);
      bus.config_out_ready_i = (cyc < cfg_hold) ? 1'b0 :
                               cfg_pend ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      in_fwd = !cfg_pend && fwd < n;
      chk("cfg_valid", bus.config_out_valid_o, cfg_pend);
      if (cfg_pend) chk("cfg_addr", bus.config_out_addr_o, addr);
      chk("idle_busy", idle, 0);
      chk("s_ready", bus.s_axis_ready_o, in_fwd & bus.axis_out_ready_i);
      chk("out_valid", bus.axis_out_valid_o,
          in_fwd & bus.s_axis_valid_i & bus.axis_out_ready_i);
      if (bus.axis_out_valid_o) begin
        chk("out_data", bus.axis_out_data_o, src_word(seed, fwd));
        fwd++;
        if (fwd == n) last_cyc = cyc;
      end
      exp_done = (last_cyc >= 0) && (cyc >= last_cyc + 2) && bus.config_out_ready_i;
      chk("done", done, exp_done);
      if (bus.s_axis_valid_i && bus.s_axis_ready_o) src_idx++;
      if (cfg_pend && bus.config_out_ready_i) cfg_pend = 0;
      if (exp_done) fin = 1;
      cyc++;
      @(posedge clk); #1;
    end
    if (!fin) chk("frame_timeout", 0, 1);
    quiet_inputs();
    @(negedge clk);
    chk("post_idle", idle, 1);
    chk("post_done", done, 0);
    chk("post_count", word_count, n);
    chk("post_short", short_f, (n < len));
    chk("post_fwd", fwd, n);
  endtask

  initial begin
    rst_n      = 1'b0;
    start_addr = '0;
    start_len  = '0;
    quiet_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_idle", idle, 1);
    chk("rst_done", done, 0);
    chk("rst_short", short_f, 0);
    chk("rst_count", word_count, 0);
    chk("rst_cfg_valid", bus.config_out_valid_o, 0);
    chk("rst_s_ready", bus.s_axis_ready_o, 0);
    chk("rst_out_valid", bus.axis_out_valid_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_frame(32'h0000_1000, 8, 0, 0, 0, 0, 0);   // basic
    run_frame(32'h0000_2000, 8, 0, 1, 1, 0, 0);   // toggling ready, random valid
    run_frame(32'h0000_3000, 16, 5, 2, 1, 1, 0);  // early last on word 5
    run_frame(32'h0000_4000, 8, 0, 2, 1, 0, 0);   // short cleared
    run_frame(32'h0000_5000, 0, 0, 0, 0, 0, 0);   // zero length
    run_frame(32'h0000_6000, 4, 0, 0, 0, 10, 0);  // config held off 10 cycles
    run_frame(32'h0000_7000, 8, 0, 0, 0, 0, 3);   // reset after word 3
    run_frame(32'h0000_7100, 8, 0, 2, 1, 2, 0);   // fresh start after abort
    run_frame(32'h0000_8000, 6, 6, 0, 1, 0, 0);   // last on final word: not short
    run_frame(32'h0000_9000, 1, 0, 1, 1, 0, 0);   // single word
    run_frame(32'h0000_9100, 3, 1, 0, 0, 0, 0);   // last on first word
    for (int f = 0; f < 6; f++) begin
      int l;
      l = $urandom_range(1, 40);
      run_frame({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, l,
                ($urandom_range(0, 1) != 0) ? $urandom_range(1, l + 3) : 0,
                $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 3), 0);
    end
    run_frame(32'hFFFF_0000, 65535, 0, 0, 0, 0, 0); // max length, no wrap

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
